// File: rtl/spu_pkg.sv
// Shared definitions for the SPU controller: widths, opcodes, FSM states,
// datapath select codes and the registered control-word layout.
// The HALT opcode is only honoured when SPU_CTRL_HALT_EN is defined.
package spu_pkg;

   localparam int unsigned PC_W  = 16;
   localparam int unsigned DM_AW = 8;
   localparam int unsigned RF_AW = 4;
   localparam int unsigned IW    = 16;
   localparam int unsigned RF_DW = 8;

   localparam logic [3:0] OP_LOAD  = 4'h0;
   localparam logic [3:0] OP_STORE = 4'h1;
   localparam logic [3:0] OP_ADD   = 4'h2;
   localparam logic [3:0] OP_LOADC = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_JMPZ  = 4'h5;
   localparam logic [3:0] OP_HALT  = 4'hF;

   typedef enum logic [3:0] {
      S_INIT, S_FETCH, S_DECODE, S_LOAD, S_STORE, S_ADD,
      S_LOADC, S_SUB, S_JMPZ, S_JMPZ_JMP, S_HALT
   } state_e;

   typedef enum logic [1:0] {
      RF_SEL_ALU = 2'b00, RF_SEL_DM = 2'b01, RF_SEL_IMM = 2'b10
   } rf_sel_e;

   typedef enum logic [1:0] {
      ALU_PASS = 2'b00, ALU_ADD = 2'b01, ALU_SUB = 2'b10
   } alu_op_e;

   typedef enum logic [1:0] {
      PC_HOLD, PC_CLEAR, PC_INC, PC_LOAD_OFS
   } pc_op_e;

   typedef struct packed {
      logic             im_rd;
      logic [DM_AW-1:0] dm_addr;
      logic             dm_rd;
      logic             dm_wr;
      rf_sel_e          rf_sel;
      logic [RF_AW-1:0] rf_w_addr;
      logic             rf_w_wr;
      logic [RF_AW-1:0] rf_rp_addr;
      logic             rf_rp_rd;
      logic [RF_AW-1:0] rf_rq_addr;
      logic             rf_rq_rd;
      logic [RF_DW-1:0] rf_w_data;
      alu_op_e          alu_op;
      logic             halted;
   } ctrl_t;

   // Control word for a state/IR pair; everything not set stays 0.
   function automatic ctrl_t decode_ctrl(input state_e st, input logic [IW-1:0] ir);
      ctrl_t c;
      c = '0;
      case (st)
         S_FETCH: c.im_rd = 1'b1;
         S_LOAD: begin
            c.dm_rd     = 1'b1;
            c.dm_addr   = ir[7:0];
            c.rf_sel    = RF_SEL_DM;
            c.rf_w_addr = ir[11:8];
            c.rf_w_wr   = 1'b1;
         end
         S_STORE: begin
            c.dm_wr      = 1'b1;
            c.dm_addr    = ir[7:0];
            c.rf_rp_addr = ir[11:8];
            c.rf_rp_rd   = 1'b1;
         end
         S_ADD, S_SUB: begin
            c.rf_rp_addr = ir[7:4];
            c.rf_rp_rd   = 1'b1;
            c.rf_rq_addr = ir[3:0];
            c.rf_rq_rd   = 1'b1;
            c.alu_op     = (st == S_ADD) ? ALU_ADD : ALU_SUB;
            c.rf_sel     = RF_SEL_ALU;
            c.rf_w_addr  = ir[11:8];
            c.rf_w_wr    = 1'b1;
         end
         S_LOADC: begin
            c.rf_sel    = RF_SEL_IMM;
            c.rf_w_data = ir[7:0];
            c.rf_w_addr = ir[11:8];
            c.rf_w_wr   = 1'b1;
         end
         S_JMPZ: begin
            c.rf_rp_addr = ir[11:8];
            c.rf_rp_rd   = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/spu_controller_if.sv
// Controller-side bus: instruction fetch, data memory and datapath controls.
interface spu_controller_if;
   import spu_pkg::*;

   logic [PC_W-1:0]  im_addr;
   logic             im_rd;
   logic [IW-1:0]    im_data;
   logic [DM_AW-1:0] dm_addr;
   logic             dm_rd;
   logic             dm_wr;
   logic             rf_s1;
   logic             rf_s0;
   logic [RF_AW-1:0] rf_w_addr;
   logic             rf_w_wr;
   logic [RF_AW-1:0] rf_rp_addr;
   logic             rf_rp_rd;
   logic [RF_AW-1:0] rf_rq_addr;
   logic             rf_rq_rd;
   logic [RF_DW-1:0] rf_w_data;
   logic             alu_s1;
   logic             alu_s0;
   logic             rf_rp_zero;
   logic             halted;

   modport master (
      output im_addr, im_rd, dm_addr, dm_rd, dm_wr, rf_s1, rf_s0,
             rf_w_addr, rf_w_wr, rf_rp_addr, rf_rp_rd, rf_rq_addr, rf_rq_rd,
             rf_w_data, alu_s1, alu_s0, halted,
      input  im_data, rf_rp_zero
   );

   modport slave (
      input  im_addr, im_rd, dm_addr, dm_rd, dm_wr, rf_s1, rf_s0,
             rf_w_addr, rf_w_wr, rf_rp_addr, rf_rp_rd, rf_rq_addr, rf_rq_rd,
             rf_w_data, alu_s1, alu_s0, halted,
      output im_data, rf_rp_zero
   );

endinterface

// File: rtl/spu_pc.sv
// Program counter: clear, increment, or relative load (PC + sext(ofs) - 1).
module spu_pc
   import spu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  pc_op_e          op_i,
   input  logic [7:0]      ofs_i,
   output logic [PC_W-1:0] pc_o
);

   logic [PC_W-1:0] pc_q, pc_d;

   // The PC already points past the jump, so the relative load backs off by one.
   always_comb begin
      pc_d = pc_q;
      case (op_i)
         PC_CLEAR:    pc_d = '0;
         PC_INC:      pc_d = pc_q + PC_W'(1);
         PC_LOAD_OFS: pc_d = pc_q + {{(PC_W-8){ofs_i[7]}}, ofs_i} - PC_W'(1);
         default:     pc_d = pc_q;
      endcase
   end

   // PC register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= '0;
      else        pc_q <= pc_d;
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/spu_controller.sv
// SPU control unit: fetch/decode/execute Moore FSM with IR and registered
// control outputs. Optional HALT instruction enabled by SPU_CTRL_HALT_EN.
module spu_controller
   import spu_pkg::*;
(
   input  logic clk,
   input  logic rst,
   spu_controller_if.master bus
);

   state_e          state_q, state_d;
   logic [IW-1:0]   ir_q, ir_d;
   ctrl_t           ctl_q, ctl_d;
   pc_op_e          pc_op;
   logic [PC_W-1:0] pc;

   spu_pc u_pc (
      .clk   (clk),
      .rst_n (rst),
      .op_i  (pc_op),
      .ofs_i (ir_q[7:0]),
      .pc_o  (pc)
   );

   // Next state, IR capture, PC operation and the control word for the next state.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      pc_op   = PC_HOLD;
      case (state_q)
         S_INIT: begin
            pc_op   = PC_CLEAR;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            ir_d    = bus.im_data;
            pc_op   = PC_INC;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            case (ir_q[15:12])
               OP_LOAD:  state_d = S_LOAD;
               OP_STORE: state_d = S_STORE;
               OP_ADD:   state_d = S_ADD;
               OP_LOADC: state_d = S_LOADC;
               OP_SUB:   state_d = S_SUB;
               OP_JMPZ:  state_d = S_JMPZ;
`ifdef SPU_CTRL_HALT_EN
               OP_HALT:  state_d = S_HALT;
`else
               OP_HALT:  state_d = S_FETCH;
`endif
               default:  state_d = S_FETCH;
            endcase
         end
         S_JMPZ:     state_d = bus.rf_rp_zero ? S_JMPZ_JMP : S_FETCH;
         S_JMPZ_JMP: begin
            pc_op   = PC_LOAD_OFS;
            state_d = S_FETCH;
         end
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_FETCH;
      endcase
      ctl_d = decode_ctrl(state_d, ir_d);
`ifdef SPU_CTRL_HALT_EN
      ctl_d.halted = (state_d == S_HALT);
`else
      ctl_d.halted = 1'b0;
`endif
   end

   // State, IR and registered outputs; reset drops every strobe immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_INIT;
         ir_q    <= '0;
         ctl_q   <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         ctl_q   <= ctl_d;
      end
   end

   assign bus.im_addr              = pc;
   assign bus.im_rd                = ctl_q.im_rd;
   assign bus.dm_addr              = ctl_q.dm_addr;
   assign bus.dm_rd                = ctl_q.dm_rd;
   assign bus.dm_wr                = ctl_q.dm_wr;
   assign {bus.rf_s1, bus.rf_s0}   = ctl_q.rf_sel;
   assign bus.rf_w_addr            = ctl_q.rf_w_addr;
   assign bus.rf_w_wr              = ctl_q.rf_w_wr;
   assign bus.rf_rp_addr           = ctl_q.rf_rp_addr;
   assign bus.rf_rp_rd             = ctl_q.rf_rp_rd;
   assign bus.rf_rq_addr           = ctl_q.rf_rq_addr;
   assign bus.rf_rq_rd             = ctl_q.rf_rq_rd;
   assign bus.rf_w_data            = ctl_q.rf_w_data;
   assign {bus.alu_s1, bus.alu_s0} = ctl_q.alu_op;
   assign bus.halted               = ctl_q.halted;

endmodule

// File: tb/tb_spu_controller.sv
// Self-checking bench for spu_controller: directed cases plus random
// instruction streams against an instruction-level reference model.
module tb_spu_controller;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model state: program counter as seen on im_addr.
   logic [15:0] pc = 16'h0000;

   // Expected outputs for the current cycle.
   logic [15:0] e_im_addr;
   logic        e_im_rd, e_dm_rd, e_dm_wr, e_w_wr, e_rp_rd, e_rq_rd, e_halted;
   logic [7:0]  e_dm_addr, e_w_data;
   logic [1:0]  e_rf_s, e_alu;
   logic [3:0]  e_w_addr, e_rp, e_rq;

   spu_controller_if bus();

   spu_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [54:0] observed();
      return {bus.im_addr, bus.im_rd, bus.dm_addr, bus.dm_rd, bus.dm_wr,
              bus.rf_s1, bus.rf_s0, bus.rf_w_addr, bus.rf_w_wr,
              bus.rf_rp_addr, bus.rf_rp_rd, bus.rf_rq_addr, bus.rf_rq_rd,
              bus.rf_w_data, bus.alu_s1, bus.alu_s0, bus.halted};
   endfunction

   task automatic clr_exp();
      e_im_addr = pc;
      e_im_rd = 0; e_dm_rd = 0; e_dm_wr = 0; e_w_wr = 0; e_rp_rd = 0;
      e_rq_rd = 0; e_halted = 0; e_dm_addr = 0; e_w_data = 0;
      e_rf_s = 0; e_alu = 0; e_w_addr = 0; e_rp = 0; e_rq = 0;
   endtask

   task automatic cmp(input string tag);
      logic [54:0] o, e;
      o = observed();
      e = {e_im_addr, e_im_rd, e_dm_addr, e_dm_rd, e_dm_wr, e_rf_s, e_w_addr,
           e_w_wr, e_rp, e_rp_rd, e_rq, e_rq_rd, e_w_data, e_alu, e_halted};
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   // Expected control outputs during the execute cycle of an instruction.
   task automatic set_exec_exp(input logic [15:0] ins);
      logic [3:0] op;
      op = ins[15:12];
      clr_exp();
      case (op)
         4'h0: begin e_dm_rd = 1; e_dm_addr = ins[7:0]; e_rf_s = 2'b01;
                     e_w_addr = ins[11:8]; e_w_wr = 1; end
         4'h1: begin e_dm_wr = 1; e_dm_addr = ins[7:0]; e_rp = ins[11:8]; e_rp_rd = 1; end
         4'h2, 4'h4: begin
                     e_rp = ins[7:4]; e_rq = ins[3:0]; e_rp_rd = 1; e_rq_rd = 1;
                     e_alu = (op == 4'h2) ? 2'b01 : 2'b10; e_rf_s = 2'b00;
                     e_w_addr = ins[11:8]; e_w_wr = 1; end
         4'h3: begin e_rf_s = 2'b10; e_w_data = ins[7:0]; e_w_addr = ins[11:8]; e_w_wr = 1; end
         4'h5: begin e_rp = ins[11:8]; e_rp_rd = 1; end
         default: ;
      endcase
   endtask

   // Fetch and decode cycles of one instruction; leaves pc at fetch address + 1.
   task automatic fetch_decode(input logic [15:0] ins, input logic z, input string tag,
                               output logic [15:0] faddr);
      @(negedge clk);
      clr_exp(); e_im_rd = 1;
      cmp({tag, "_fetch"});
      bus.im_data = ins;
      bus.rf_rp_zero = z;
      faddr = pc;
      pc = pc + 16'd1;
      @(negedge clk);
      clr_exp();
      cmp({tag, "_decode"});
   endtask

   // One complete instruction; returns with the next cycle being a fetch.
   task automatic run_instr(input logic [15:0] ins, input logic z, input string tag);
      logic [15:0] faddr;
      logic [3:0]  op;
      int          ofs;
      op = ins[15:12];
      fetch_decode(ins, z, tag, faddr);
      if (op <= 4'h5) begin
         @(negedge clk);
         set_exec_exp(ins);
         cmp({tag, "_exec"});
      end
      if (op == 4'h5 && z) begin
         @(negedge clk);
         clr_exp();
         cmp({tag, "_jmp"});
         ofs = int'($signed(ins[7:0]));
         pc = 16'(int'(faddr) + ofs);
      end
   endtask

   initial begin
      logic [15:0] ins, faddr;
      logic        z;
      bus.im_data = 16'h0000;
      bus.rf_rp_zero = 1'b0;

      // Held in reset: only im_addr=0, all else 0.
      repeat (2) begin
         @(negedge clk);
         clr_exp();
         cmp("reset");
      end
      rst = 1'b1;

      // Directed instructions from address 0.
      run_instr(16'h3A55, 1'b0, "loadc");
      run_instr(16'h2123, 1'b0, "add");
      run_instr(16'h4123, 1'b0, "sub");
      run_instr(16'h0407, 1'b0, "load");
      run_instr(16'h1408, 1'b0, "store");
      run_instr(16'h52FE, 1'b1, "jmpz_taken");     // at PC=5 -> 3
      run_instr(16'h7000, 1'b0, "nop3");
      run_instr(16'h8000, 1'b0, "nop4");
      run_instr(16'h52FE, 1'b0, "jmpz_not");       // at PC=5 -> 6
      run_instr(16'h50F9, 1'b1, "jmp_to_ffff");    // 6 - 7 -> FFFF
      run_instr(16'h6000, 1'b0, "nop_ffff");       // wraps to 0
`ifndef SPU_CTRL_HALT_EN
      run_instr(16'hF000, 1'b0, "halt_as_nop");
`endif

      // Random instruction stream.
      for (int i = 0; i < 60; i++) begin
         ins = 16'($urandom);
`ifdef SPU_CTRL_HALT_EN
         if (ins[15:12] == 4'hF) ins[15:12] = 4'h6;
`endif
         z = 1'($urandom_range(0, 1));
         run_instr(ins, z, "rand");
      end

      // Reset during an ADD execute cycle drops rf_w_wr at once.
      fetch_decode(16'h2567, 1'b0, "abort", faddr);
      @(negedge clk);
      set_exec_exp(16'h2567);
      cmp("abort_exec");
      #1 rst = 1'b0;
      #1 pc = 16'h0000;
      clr_exp();
      cmp("abort_rst");
      @(negedge clk);
      cmp("abort_hold");
      rst = 1'b1;
      run_instr(16'h3B12, 1'b0, "after_rst");

`ifdef SPU_CTRL_HALT_EN
      // HALT: halted=1, PC held, no further fetches.
      fetch_decode(16'hF000, 1'b0, "halt", faddr);
      repeat (4) begin
         @(negedge clk);
         clr_exp(); e_halted = 1;
         cmp("halt_state");
      end
`else
      run_instr(16'hF000, 1'b0, "halt_nop_end");
      @(negedge clk);
      clr_exp(); e_im_rd = 1;
      cmp("fetch_after_nop");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
